// File: rtl/lpif_ll_tx_credit_fifo.sv
// Logic-link transmit stage: buffers packed LPIF words and forwards one per cycle
// to channel striping while the far-end receive FIFO has advertised credit.
module lpif_ll_tx_credit_fifo #(
    parameter int WIDTH      = 269,
    parameter int DEPTH      = 4,
    parameter int MAX_CREDIT = 8,
    parameter int CW         = $clog2(MAX_CREDIT + 1)
) (
    input  logic             clk_wr,
    input  logic             rst_wr_n,
    input  logic [WIDTH-1:0] txfifo_downstream_data,
    input  logic             txfifo_downstream_push,
    output logic             txfifo_full,
    output logic [WIDTH-1:0] ll_tx_data,
    output logic             ll_tx_valid,
    input  logic             rx_online,
    input  logic             tx_credit_return,
    output logic [CW-1:0]    tx_credit_count,
    output logic             tx_overflow,
    output logic             tx_credit_error
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   PTR_ONE     = (AW + 1)'(1);
    localparam logic [AW:0]   FULL_COUNT  = (AW + 1)'(DEPTH);
    localparam logic [CW-1:0] CREDIT_ONE  = CW'(1);
    localparam logic [CW-1:0] CREDIT_INIT = CW'(MAX_CREDIT);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [AW:0]      count;
    logic [AW:0]      count_next;
    logic             do_push;
    logic             do_pop;

    // Pointers carry one wrap bit, so the plain difference is the occupancy.
    assign count      = wr_ptr - rd_ptr;
    assign do_push    = txfifo_downstream_push && !txfifo_full;
    assign do_pop     = (count != '0) && (tx_credit_count != '0) && rx_online;
    assign count_next = count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};

    // NOTE: the storage array has no reset; emptiness is carried entirely by the
    // pointers, so resetting WIDTH*DEPTH flops would buy nothing.
    always_ff @(posedge clk_wr) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= txfifo_downstream_data;
        end
    end

    always_ff @(posedge clk_wr or negedge rst_wr_n) begin
        if (!rst_wr_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            txfifo_full <= 1'b0;
            tx_overflow <= 1'b0;
            ll_tx_valid <= 1'b0;
            ll_tx_data  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr     <= rd_ptr + PTR_ONE;
                ll_tx_data <= mem[rd_ptr[AW-1:0]];
            end
            ll_tx_valid <= do_pop;
            txfifo_full <= (count_next == FULL_COUNT);
            // A push against a full FIFO is lost even if a pop frees a slot this cycle.
            if (txfifo_downstream_push && txfifo_full) begin
                tx_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_wr or negedge rst_wr_n) begin
        if (!rst_wr_n) begin
            tx_credit_count <= CREDIT_INIT;
            tx_credit_error <= 1'b0;
        end else if (!rx_online) begin
            tx_credit_count <= CREDIT_INIT;
        end else if (tx_credit_return && !do_pop) begin
            if (tx_credit_count == CREDIT_INIT) begin
                tx_credit_error <= 1'b1;
            end else begin
                tx_credit_count <= tx_credit_count + CREDIT_ONE;
            end
        end else if (!tx_credit_return && do_pop) begin
            tx_credit_count <= tx_credit_count - CREDIT_ONE;
        end
    end

endmodule

// File: tb/tb_lpif_ll_tx_credit_fifo.sv
// Directed bench for lpif_ll_tx_credit_fifo: latency, credit starvation, overflow,
// pop/return balance, credit error, link drop and asynchronous reset.
module tb_lpif_ll_tx_credit_fifo;

    localparam int WIDTH      = 269;
    localparam int DEPTH      = 4;
    localparam int MAX_CREDIT = 8;
    localparam int CW         = $clog2(MAX_CREDIT + 1);

    logic             clk_wr;
    logic             rst_wr_n;
    logic [WIDTH-1:0] txfifo_downstream_data;
    logic             txfifo_downstream_push;
    logic             txfifo_full;
    logic [WIDTH-1:0] ll_tx_data;
    logic             ll_tx_valid;
    logic             rx_online;
    logic             tx_credit_return;
    logic [CW-1:0]    tx_credit_count;
    logic             tx_overflow;
    logic             tx_credit_error;

    int n_checks = 0;
    int n_fail   = 0;

    lpif_ll_tx_credit_fifo #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .MAX_CREDIT(MAX_CREDIT)
    ) dut (
        .clk_wr                (clk_wr),
        .rst_wr_n              (rst_wr_n),
        .txfifo_downstream_data(txfifo_downstream_data),
        .txfifo_downstream_push(txfifo_downstream_push),
        .txfifo_full           (txfifo_full),
        .ll_tx_data            (ll_tx_data),
        .ll_tx_valid           (ll_tx_valid),
        .rx_online             (rx_online),
        .tx_credit_return      (tx_credit_return),
        .tx_credit_count       (tx_credit_count),
        .tx_overflow           (tx_overflow),
        .tx_credit_error       (tx_credit_error)
    );

    initial clk_wr = 1'b0;
    always #5 clk_wr = ~clk_wr;

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_word(input string tag, input logic [WIDTH-1:0] obs,
                              input logic [WIDTH-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk_wr);
        #1;
    endtask

    function automatic logic [WIDTH-1:0] word(input int i);
        logic [WIDTH-1:0] w;
        w = '0;
        w[WIDTH-1 -: 8] = 8'(i);
        w[140 -: 8]     = ~8'(i);
        w[15:0]         = 16'(i) ^ 16'hA5A5;
        return w;
    endfunction

    task automatic apply_reset();
        rst_wr_n               = 1'b0;
        txfifo_downstream_push = 1'b0;
        txfifo_downstream_data = '0;
        tx_credit_return       = 1'b0;
        rx_online              = 1'b0;
        tick();
        tick();
        rst_wr_n = 1'b1;
    endtask

    initial begin
        int n_sent;

        apply_reset();
        check_bit("rst_valid", ll_tx_valid, 1'b0);
        check_word("rst_data", ll_tx_data, '0);
        check_bit("rst_full", txfifo_full, 1'b0);
        check_int("rst_credit", int'(tx_credit_count), 8);
        check_bit("rst_overflow", tx_overflow, 1'b0);
        check_bit("rst_credit_error", tx_credit_error, 1'b0);

        // Single word: two-cycle latency, one credit consumed.
        rx_online              = 1'b1;
        txfifo_downstream_push = 1'b1;
        txfifo_downstream_data = WIDTH'(20'h1_2345);
        tick();
        txfifo_downstream_push = 1'b0;
        check_bit("single_valid_c1", ll_tx_valid, 1'b0);
        tick();
        check_bit("single_valid_c2", ll_tx_valid, 1'b1);
        check_word("single_data", ll_tx_data, WIDTH'(20'h1_2345));
        tick();
        check_bit("single_valid_c3", ll_tx_valid, 1'b0);
        check_int("single_credit", int'(tx_credit_count), 7);

        // Credit error: return to 8, then one return too many.
        tx_credit_return = 1'b1;
        tick();
        tx_credit_return = 1'b0;
        check_int("cerr_refill", int'(tx_credit_count), 8);
        check_bit("cerr_clear", tx_credit_error, 1'b0);
        tx_credit_return = 1'b1;
        tick();
        tx_credit_return = 1'b0;
        check_int("cerr_saturate", int'(tx_credit_count), 8);
        check_bit("cerr_set", tx_credit_error, 1'b1);
        tick();
        check_bit("cerr_sticky", tx_credit_error, 1'b1);

        // Credit starvation: 12 words, only 8 may leave.
        n_sent = 0;
        for (int i = 0; i < 12; i++) begin
            txfifo_downstream_push = 1'b1;
            txfifo_downstream_data = word(i);
            tick();
            if (ll_tx_valid) begin
                check_word("starve_data", ll_tx_data, word(n_sent));
                n_sent++;
            end
        end
        txfifo_downstream_push = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (ll_tx_valid) begin
                check_word("starve_data", ll_tx_data, word(n_sent));
                n_sent++;
            end
        end
        check_int("starve_sent", n_sent, 8);
        check_int("starve_credit", int'(tx_credit_count), 0);
        check_bit("starve_full", txfifo_full, 1'b1);
        check_bit("starve_no_overflow", tx_overflow, 1'b0);
        tx_credit_return = 1'b1;
        tick();
        tx_credit_return = 1'b0;
        check_bit("return_valid_c1", ll_tx_valid, 1'b0);
        check_int("return_credit_c1", int'(tx_credit_count), 1);
        tick();
        check_bit("return_valid_c2", ll_tx_valid, 1'b1);
        check_word("return_data", ll_tx_data, word(8));
        check_int("return_credit_c2", int'(tx_credit_count), 0);
        check_bit("return_full_clear", txfifo_full, 1'b0);
        tick();
        check_bit("return_single_word", ll_tx_valid, 1'b0);

        // Overflow with the link down, then drain in order.
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            txfifo_downstream_push = 1'b1;
            txfifo_downstream_data = word(100 + i);
            tick();
            if (i == 2) check_bit("ovf_full_after_3", txfifo_full, 1'b0);
            if (i == 3) begin
                check_bit("ovf_full_after_4", txfifo_full, 1'b1);
                check_bit("ovf_clear_after_4", tx_overflow, 1'b0);
            end
        end
        txfifo_downstream_push = 1'b0;
        check_bit("ovf_set", tx_overflow, 1'b1);
        check_bit("ovf_no_valid_offline", ll_tx_valid, 1'b0);
        rx_online = 1'b1;
        n_sent    = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (ll_tx_valid) begin
                check_word("ovf_drain_data", ll_tx_data, word(100 + n_sent));
                n_sent++;
            end
        end
        check_int("ovf_drain_count", n_sent, 4);
        check_int("ovf_credit", int'(tx_credit_count), 4);
        check_bit("ovf_full_drained", txfifo_full, 1'b0);
        check_bit("ovf_sticky", tx_overflow, 1'b1);

        // Simultaneous pop and return hold credit at 3 with continuous valid.
        txfifo_downstream_push = 1'b1;
        txfifo_downstream_data = word(20);
        tick();
        txfifo_downstream_data = word(21);
        tick();
        check_bit("bal_first_valid", ll_tx_valid, 1'b1);
        check_int("bal_first_credit", int'(tx_credit_count), 3);
        tx_credit_return = 1'b1;
        for (int j = 0; j < 6; j++) begin
            txfifo_downstream_data = word(22 + j);
            tick();
            check_bit("bal_valid", ll_tx_valid, 1'b1);
            check_int("bal_credit", int'(tx_credit_count), 3);
            check_word("bal_data", ll_tx_data, word(21 + j));
        end
        txfifo_downstream_push = 1'b0;
        tx_credit_return       = 1'b0;
        tick();
        check_bit("bal_last_valid", ll_tx_valid, 1'b1);
        check_word("bal_last_data", ll_tx_data, word(27));
        check_int("bal_last_credit", int'(tx_credit_count), 2);
        tick();
        check_bit("bal_idle", ll_tx_valid, 1'b0);

        // Link drop mid-stream with two words queued.
        apply_reset();
        rx_online              = 1'b1;
        txfifo_downstream_push = 1'b1;
        txfifo_downstream_data = word(30);
        tick();
        txfifo_downstream_data = word(31);
        tick();
        check_word("drop_data_30", ll_tx_data, word(30));
        txfifo_downstream_data = word(32);
        tick();
        check_bit("drop_valid_before", ll_tx_valid, 1'b1);
        check_word("drop_data_31", ll_tx_data, word(31));
        check_int("drop_credit_before", int'(tx_credit_count), 6);
        rx_online              = 1'b0;
        txfifo_downstream_data = word(33);
        tick();
        txfifo_downstream_push = 1'b0;
        check_bit("drop_valid_after", ll_tx_valid, 1'b0);
        check_int("drop_credit_reload", int'(tx_credit_count), 8);
        tx_credit_return = 1'b1;
        tick();
        tx_credit_return = 1'b0;
        check_int("drop_return_ignored", int'(tx_credit_count), 8);
        check_bit("drop_no_cerr", tx_credit_error, 1'b0);
        check_word("drop_data_hold", ll_tx_data, word(31));
        rx_online = 1'b1;
        tick();
        check_bit("restore_valid_32", ll_tx_valid, 1'b1);
        check_word("restore_data_32", ll_tx_data, word(32));
        check_int("restore_credit_32", int'(tx_credit_count), 7);
        tick();
        check_word("restore_data_33", ll_tx_data, word(33));
        check_int("restore_credit_33", int'(tx_credit_count), 6);
        tick();
        check_bit("restore_idle", ll_tx_valid, 1'b0);

        // Asynchronous reset mid-stream.
        txfifo_downstream_push = 1'b1;
        txfifo_downstream_data = word(40);
        tick();
        txfifo_downstream_data = word(41);
        tick();
        txfifo_downstream_data = word(42);
        tick();
        check_bit("mid_valid", ll_tx_valid, 1'b1);
        check_int("mid_credit", int'(tx_credit_count), 4);
        txfifo_downstream_push = 1'b0;
        rst_wr_n               = 1'b0;
        #1;
        check_bit("arst_valid", ll_tx_valid, 1'b0);
        check_word("arst_data", ll_tx_data, '0);
        check_int("arst_credit", int'(tx_credit_count), 8);
        check_bit("arst_full", txfifo_full, 1'b0);
        check_bit("arst_overflow", tx_overflow, 1'b0);
        tick();
        rst_wr_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_bit("arst_discarded", ll_tx_valid, 1'b0);
        end
        check_int("arst_credit_idle", int'(tx_credit_count), 8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lpif_ll_tx_credit_fifo.md
# lpif_ll_tx_credit_fifo

Logic-link transmit stage placed directly downstream of the LPIF x4 quarter-rate packing block. It buffers the packed 269-bit downstream word (`txfifo_downstream_data`) in a small FIFO and forwards each word to the AIB channel-striping logic only when the far-end receive FIFO has advertised a free credit. Credits are consumed on each forwarded word and returned by single-cycle pulses from the far end.

## Interface
- `WIDTH`, 269: packed LPIF word width.
- `DEPTH`, 4: FIFO entries; power of 2, ≥2.
- `MAX_CREDIT`, 8: far-end RX FIFO depth; also the initial credit count.
- `CW`, $clog2(MAX_CREDIT+1): credit counter width. Derived; not overridden.

Ports:
- `clk_wr`  in  1  block clock. One clock; all logic on the rising edge.
- `rst_wr_n`  in  1  reset, asynchronous assert, active-low.
- `txfifo_downstream_data`  in  WIDTH  packed word from the LPIF packing block.
- `txfifo_downstream_push`  in  1  write strobe for `txfifo_downstream_data`.
- `txfifo_full`  out  1  FIFO holds DEPTH entries.
- `ll_tx_data`  out  WIDTH  word to channel striping.
- `ll_tx_valid`  out  1  `ll_tx_data` valid this cycle (single-cycle per word).
- `rx_online`  in  1  far end is up and accepting traffic.
- `tx_credit_return`  in  1  one-cycle pulse; far end freed one entry.
- `tx_credit_count`  out  CW  credits currently available.
- `tx_overflow`  out  1  sticky; a push was dropped.
- `tx_credit_error`  out  1  sticky; a credit return arrived at MAX_CREDIT.

## Operation
- FIFO: binary read and write pointers, each with one wrap bit. count = wr − rd. `txfifo_full` = (count == DEPTH), registered.
- Push: when `txfifo_downstream_push` is high and the FIFO is not full, the word is written at wr and wr increments. When full, the word is dropped and `tx_overflow` is set. This applies even if a pop occurs in the same cycle.
- Pop condition, evaluated each cycle: count ≠ 0 AND `tx_credit_count` ≠ 0 AND `rx_online`. When true:
  - `ll_tx_data` <= head entry
  - `ll_tx_valid` <= 1
  - rd increments
  - credit decrements
- When the pop condition is false, `ll_tx_valid` <= 0 and `ll_tx_data` holds its last value.
- Credit update per cycle, with rx_online = 1:
  - Return and pop in the same cycle: net 0.
  - Return only: +1. If the count is already MAX_CREDIT, it saturates and `tx_credit_error` is set.
  - Pop only: −1.
- With rx_online = 0:
  - Credit counter is loaded with MAX_CREDIT.
  - Returns are ignored.
  - No pops occur.
  - FIFO contents are retained.
  - Pushes continue normally.
- Sticky flags clear only on reset.
- Pointer wrap is natural modulo 2·DEPTH. Pointers never need a compare beyond the wrap bit.

## Timing
- Reset values:
  - `ll_tx_valid` = 0
  - `ll_tx_data` = 0
  - `txfifo_full` = 0
  - `tx_credit_count` = MAX_CREDIT
  - `tx_overflow` = 0
  - `tx_credit_error` = 0
  - pointers = 0
- Latency: a push sampled at edge N makes the entry visible at cycle N+1. The earliest pop is decided in N+1, so `ll_tx_valid` is high in cycle N+2 (2 cycles).
- Throughput: one word per cycle while credits > 0 and the FIFO is non-empty.
- `txfifo_full` asserts the cycle after the DEPTH-th entry is written. It deasserts the cycle after a pop that leaves count < DEPTH.
- `tx_credit_count` reflects its update one cycle after the pop or return.
- `rx_online` falling at cycle N: no pop is decided in N, so `ll_tx_valid` = 0 from N+1. A word already registered in N is still presented in N. Credits read MAX_CREDIT from N+1.
- `rx_online` rising: pops resume in the first cycle that `rx_online` is sampled high.
- Reset mid-stream: all FIFO content is discarded; outputs take reset values asynchronously.

## Test plan
- **Single word:** `rx_online` = 1. Push word 0x1_2345 at cycle 0 → `ll_tx_valid` in cycle 2 with that data; credit 8→7 visible in cycle 3.
- **Credit starvation:** MAX_CREDIT = 8, no returns. Push 12 words back-to-back → exactly 8 `ll_tx_valid` pulses; credit reaches 0; FIFO holds 4 and `txfifo_full` = 1. One `tx_credit_return` → exactly 1 more word is sent.
- **Overflow:** `rx_online` = 0. Push 5 words → `txfifo_full` after the 4th; 5th dropped; `tx_overflow` = 1. Raise `rx_online` → 4 words sent in order; 5th never appears.
- **Simultaneous pop and return:** steady stream at credit = 3 with a return pulse every cycle → credit stays 3 and `ll_tx_valid` stays continuously high.
- **Credit error:** idle, credit = 8. Pulse `tx_credit_return` → count stays 8; `tx_credit_error` = 1 and stays set.
- **Link drop / reset:** drop `rx_online` mid-stream with 2 words queued → `ll_tx_valid` = 0 from the next cycle; credit = 8. Restore → 2 queued words sent. Assert `rst_wr_n` low mid-stream → all outputs return to reset values immediately.
